// File: rtl/dma_copy.sv
// dma_copy: single-channel element copy engine.
//
// On an accepted start the engine latches the request and copies len elements from src_addr to
// dst_addr in ascending order. Each element takes one read cycle (RD) and one write cycle (WR).
// Requests that are misaligned, that run past IO_BOUNDARY, or that wrap the 32-bit address space
// are rejected with a one-cycle err pulse. No memory access is made for a rejected request.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      request pulse, sampled only while idle
//   src_addr   byte address of the first source element
//   dst_addr   byte address of the first destination element
//   len        element count
//   width      element size: 000 word, 001 half, 010 byte, other codes treated as word
//   mem_rdata  combinational read data for mem_addr/mem_width
//   mem_addr   memory byte address (0 when not accessing)
//   mem_wdata  store data (0 when not writing)
//   mem_wen    store enable
//   mem_width  access width (effective element width, 0 when not accessing)
//   busy       high while reading or writing elements
//   done       one-cycle pulse when a copy completes
//   err        one-cycle pulse when a request is rejected
module dma_copy #(
   parameter logic [31:0] IO_BOUNDARY = 32'hBFC00FFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] src_addr,
   input  logic [31:0] dst_addr,
   input  logic [15:0] len,
   input  logic [2:0]  width,
   input  logic [31:0] mem_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_wen,
   output logic [2:0]  mem_width,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {StIdle, StRd, StWr, StDone, StErr} state_e;

   state_e      state_q, state_d;
   logic [31:0] src_q, dst_q, buf_q;
   logic [15:0] len_q, cnt_q;
   logic [2:0]  width_q;

   // Unknown width codes collapse to word.
   function automatic logic [2:0] eff_width(input logic [2:0] w);
      return (w == 3'b001 || w == 3'b010) ? w : 3'b000;
   endfunction

   // log2 of the element size in bytes.
   function automatic logic [1:0] size_shift(input logic [2:0] w);
      unique case (w)
         3'b001:  return 2'd1;
         3'b010:  return 2'd0;
         default: return 2'd2;
      endcase
   endfunction

   // Request validation, evaluated on the raw inputs in the accept cycle.
   logic [1:0]  in_shift;
   logic [32:0] span, src_end, dst_end;
   logic        misalign, range_bad, reject;

   always_comb begin
      in_shift = size_shift(width);
      span     = 33'(len) << in_shift;
      // 33-bit ends so a wrap past 2^32 shows up in bit 32.
      src_end  = {1'b0, src_addr} + span - 33'd1;
      dst_end  = {1'b0, dst_addr} + span - 33'd1;
      misalign = 1'b0;
      if (in_shift == 2'd2) begin
         misalign = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);
      end else if (in_shift == 2'd1) begin
         misalign = src_addr[0] || dst_addr[0];
      end
      // An empty range has no end address, so only non-empty ranges are bounds-checked.
      range_bad = (len != 16'd0) &&
                  (src_end > {1'b0, IO_BOUNDARY} || dst_end > {1'b0, IO_BOUNDARY} ||
                   src_end[32] || dst_end[32]);
      reject    = misalign || range_bad;
   end

   logic [31:0] offset;
   assign offset = 32'(cnt_q) << size_shift(width_q);

   always_comb begin
      state_d   = state_q;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      mem_wen   = 1'b0;
      mem_width = 3'b000;
      busy      = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (reject) begin
                  state_d = StErr;
               end else if (len == 16'd0) begin
                  state_d = StDone;
               end else begin
                  state_d = StRd;
               end
            end
         end
         StRd: begin
            busy      = 1'b1;
            mem_addr  = src_q + offset;
            mem_width = width_q;
            state_d   = StWr;
         end
         StWr: begin
            busy      = 1'b1;
            mem_addr  = dst_q + offset;
            mem_wdata = buf_q;
            mem_wen   = 1'b1;
            mem_width = width_q;
            state_d   = (cnt_q + 16'd1 == len_q) ? StDone : StRd;
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         StErr: begin
            err     = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         src_q   <= 32'd0;
         dst_q   <= 32'd0;
         len_q   <= 16'd0;
         cnt_q   <= 16'd0;
         width_q <= 3'b000;
         buf_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         if (state_q == StIdle && start) begin
            src_q   <= src_addr;
            dst_q   <= dst_addr;
            len_q   <= len;
            width_q <= eff_width(width);
            cnt_q   <= 16'd0;
         end
         if (state_q == StRd) begin
            buf_q <= mem_rdata;
         end
         if (state_q == StWr) begin
            cnt_q <= cnt_q + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_dma_copy.sv
// Bench for dma_copy: byte-array memory window at 0x10000 (4 KiB, addresses folded into the
// window), a shadow image updated by an element-copy model, and a queue of expected writes.
module tb_dma_copy;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] src_addr, dst_addr;
   logic [15:0] len;
   logic [2:0]  width;
   logic [31:0] mem_rdata, mem_addr, mem_wdata;
   logic        mem_wen;
   logic [2:0]  mem_width;
   logic        busy, done, err;

   always #5 clk = ~clk;

   dma_copy dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .src_addr  (src_addr),
      .dst_addr  (dst_addr),
      .len       (len),
      .width     (width),
      .mem_rdata (mem_rdata),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wen   (mem_wen),
      .mem_width (mem_width),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   typedef struct {
      logic [31:0] src;
      logic [31:0] dst;
      logic [15:0] len;
      logic [2:0]  width;
      bit          exp_err;
   } vec_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  wd;
   } wr_t;

   logic [7:0] mem      [0:4095];
   logic [7:0] init_img [0:4095];
   logic [7:0] shadow   [0:4095];
   logic       fill_en = 1'b0;
   wr_t        exp_q[$];
   int         checks = 0;
   int         failures = 0;

   function automatic logic [11:0] idx(input logic [31:0] a);
      logic [31:0] d;
      d = a - 32'h0001_0000;
      return d[11:0];
   endfunction

   function automatic int size_of(input logic [2:0] w);
      if (w == 3'b001) return 2;
      if (w == 3'b010) return 1;
      return 4;
   endfunction

   function automatic logic [2:0] eff_of(input logic [2:0] w);
      if (w == 3'b001 || w == 3'b010) return w;
      return 3'b000;
   endfunction

   logic [11:0] acc_i;
   assign acc_i = idx(mem_addr);

   always_comb begin
      mem_rdata = 32'd0;
      case (mem_width)
         3'b010:  mem_rdata = {24'd0, mem[acc_i]};
         3'b001:  mem_rdata = {16'd0, mem[acc_i + 12'd1], mem[acc_i]};
         default: mem_rdata = {mem[acc_i + 12'd3], mem[acc_i + 12'd2],
                               mem[acc_i + 12'd1], mem[acc_i]};
      endcase
   end

   always @(posedge clk) begin
      if (fill_en) begin
         for (int i = 0; i < 4096; i++) mem[i] <= init_img[i];
      end else if (mem_wen) begin
         mem[acc_i] <= mem_wdata[7:0];
         if (mem_width != 3'b010) mem[acc_i + 12'd1] <= mem_wdata[15:8];
         if (mem_width != 3'b010 && mem_width != 3'b001) begin
            mem[acc_i + 12'd2] <= mem_wdata[23:16];
            mem[acc_i + 12'd3] <= mem_wdata[31:24];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic fill_pattern(input int seed);
      for (int i = 0; i < 4096; i++) begin
         init_img[i] = 8'(i * 13 + seed * 29 + 5);
         shadow[i]   = init_img[i];
      end
   endtask

   task automatic set_word(input logic [31:0] a, input logic [31:0] w);
      for (int b = 0; b < 4; b++) begin
         init_img[idx(a) + 12'(b)] = w[8*b +: 8];
         shadow[idx(a) + 12'(b)]   = w[8*b +: 8];
      end
   endtask

   task automatic commit_fill();
      @(negedge clk);
      fill_en = 1'b1;
      @(posedge clk);
      #1 fill_en = 1'b0;
   endtask

   function automatic logic [31:0] rd_word(input logic [31:0] a);
      return {mem[idx(a) + 12'd3], mem[idx(a) + 12'd2], mem[idx(a) + 12'd1], mem[idx(a)]};
   endfunction

   // Element-by-element copy on the shadow image; queues the writes the DUT must make.
   task automatic model_copy(input vec_t v);
      int          sz;
      logic [31:0] a_s, a_d, data;
      wr_t         e;
      sz = size_of(v.width);
      exp_q.delete();
      if (!v.exp_err) begin
         for (int i = 0; i < int'(v.len); i++) begin
            a_s  = v.src + 32'(i * sz);
            a_d  = v.dst + 32'(i * sz);
            data = 32'd0;
            for (int b = 0; b < sz; b++) data[8*b +: 8] = shadow[idx(a_s) + 12'(b)];
            for (int b = 0; b < sz; b++) shadow[idx(a_d) + 12'(b)] = data[8*b +: 8];
            e.addr = a_d;
            e.data = data;
            e.wd   = eff_of(v.width);
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic drive_start(input vec_t v);
      @(negedge clk);
      src_addr = v.src;
      dst_addr = v.dst;
      len      = v.len;
      width    = v.width;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      // Scramble inputs; the latched request must be unaffected.
      src_addr = ~v.src;
      dst_addr = v.dst + 32'h40;
      len      = v.len + 16'd3;
      width    = v.width ^ 3'b011;
   endtask

   task automatic check_write();
      wr_t e;
      if (mem_wen) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual=%h required=no_write", mem_addr);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", mem_addr, e.addr);
            chk("wr_data", mem_wdata, e.data);
            chk("wr_width", {29'd0, mem_width}, {29'd0, e.wd});
         end
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int cycles, busy_n, mism;
      model_copy(v);
      drive_start(v);
      cycles = 1;
      busy_n = 0;
      while (cycles < 300) begin
         check_write();
         if (done || err) break;
         if (busy) busy_n++;
         start = busy;  // start while busy must be ignored
         @(posedge clk);
         #1 cycles++;
      end
      start = 1'b0;
      chk({tag, "_latency"}, cycles, v.exp_err ? 1 : 2 * int'(v.len) + 1);
      chk({tag, "_done"}, {31'd0, done}, {31'd0, !v.exp_err});
      chk({tag, "_err"}, {31'd0, err}, {31'd0, v.exp_err});
      chk({tag, "_busy_cycles"}, busy_n, v.exp_err ? 0 : 2 * int'(v.len));
      chk({tag, "_busy_at_end"}, {31'd0, busy}, 32'd0);
      chk({tag, "_writes_left"}, exp_q.size(), 0);
      @(posedge clk);
      #1;
      chk({tag, "_idle_flags"}, {28'd0, busy, done, err, mem_wen}, 32'd0);
      chk({tag, "_idle_addr"}, mem_addr, 32'd0);
      mism = 0;
      for (int i = 0; i < 4096; i++) if (mem[i] !== shadow[i]) mism++;
      chk({tag, "_mem_image"}, mism, 0);
   endtask

   vec_t        vecs [10];
   logic [31:0] v0_words [4];

   initial begin
      vec_t ov, rv;
      int   cyc;

      rst = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0; width = '0;
      #1;
      chk("reset_flags", {28'd0, busy, done, err, mem_wen}, 32'd0);
      chk("reset_addr", mem_addr, 32'd0);
      chk("reset_wdata", mem_wdata, 32'd0);
      chk("reset_width", {29'd0, mem_width}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;

      vecs[0] = '{32'h0001_0000, 32'h0001_0100, 16'd4, 3'b000, 1'b0};
      vecs[1] = '{32'h0001_0003, 32'h0001_0201, 16'd3, 3'b010, 1'b0};
      vecs[2] = '{32'h0001_0001, 32'h0001_0100, 16'd2, 3'b001, 1'b1};
      vecs[3] = '{32'h0001_0000, 32'hBFC0_0FFC, 16'd2, 3'b000, 1'b1};
      vecs[4] = '{32'h0001_0000, 32'h0001_0100, 16'd0, 3'b000, 1'b0};
      vecs[5] = '{32'h0001_0010, 32'h0001_0302, 16'd5, 3'b001, 1'b0};
      vecs[6] = '{32'h0001_0020, 32'h0001_0340, 16'd2, 3'b011, 1'b0};
      vecs[7] = '{32'hFFFF_FFFC, 32'h0001_0100, 16'd2, 3'b000, 1'b1};
      vecs[8] = '{32'h0001_0040, 32'hBFC0_0FFC, 16'd1, 3'b000, 1'b0};
      vecs[9] = '{32'h0001_0000, 32'h0001_0102, 16'd1, 3'b000, 1'b1};
      v0_words = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC, 32'hDDEE_FF00};

      for (int vi = 0; vi < 10; vi++) begin
         fill_pattern(vi);
         if (vi == 0) for (int k = 0; k < 4; k++) set_word(32'h0001_0000 + 32'(4 * k), v0_words[k]);
         commit_fill();
         run_vec(vecs[vi], $sformatf("v%0d", vi));
         if (vi == 0) begin
            for (int k = 0; k < 4; k++)
               chk($sformatf("v0_dst_word%0d", k), rd_word(32'h0001_0100 + 32'(4 * k)), v0_words[k]);
         end
         if (vi == 1) begin
            chk("v1_below_byte", {24'd0, mem[idx(32'h0001_0200)]}, {24'd0, init_img[idx(32'h0001_0200)]});
            chk("v1_above_byte", {24'd0, mem[idx(32'h0001_0204)]}, {24'd0, init_img[idx(32'h0001_0204)]});
         end
      end

      // Overlapping ascending copy propagates A forward.
      fill_pattern(77);
      set_word(32'h0001_0000, 32'hA0A0_0001);
      set_word(32'h0001_0004, 32'hB0B0_0002);
      set_word(32'h0001_0008, 32'hC0C0_0003);
      set_word(32'h0001_000C, 32'hD0D0_0004);
      commit_fill();
      ov = '{32'h0001_0000, 32'h0001_0004, 16'd3, 3'b000, 1'b0};
      run_vec(ov, "ovl");
      for (int k = 0; k < 4; k++)
         chk($sformatf("ovl_word%0d", k), rd_word(32'h0001_0000 + 32'(4 * k)), 32'hA0A0_0001);

      // Reset during WR of the second element.
      fill_pattern(91);
      commit_fill();
      rv = '{32'h0001_0000, 32'h0001_0100, 16'd4, 3'b000, 1'b0};
      model_copy(rv);
      drive_start(rv);
      cyc = 1;
      while (cyc < 4) begin
         @(posedge clk);
         #1 cyc++;
      end
      chk("rst_pre_wen", {31'd0, mem_wen}, 32'd1);
      chk("rst_pre_addr", mem_addr, 32'h0001_0104);
      #2 rst = 1'b0;
      #1;
      chk("rst_wen", {31'd0, mem_wen}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      @(posedge clk);
      #1 chk("rst_no_done", {31'd0, done}, 32'd0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1 chk("rst_stays_idle", {30'd0, busy, done}, 32'd0);
      exp_q.delete();

      fill_pattern(92);
      commit_fill();
      run_vec(vecs[5], "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
